// File: rtl/button_debounce.sv
// Two-flop (or deeper) synchronizer plus 4-state debounce FSM producing a clean, registered level.
// Optional saturating glitch counter enabled by defining BUTTON_DEBOUNCE_GLITCH_COUNT_EN.
module button_debounce #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 650000,
   parameter bit INVERT        = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       raw_in,
   output logic       level,
   output logic       busy,
   output logic [7:0] glitch_count
);
   localparam int               CNT_W     = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic             IDLE_RAW  = INVERT;

   localparam logic [1:0] ST_STABLE_LO = 2'd0;
   localparam logic [1:0] ST_WAIT_HI   = 2'd1;
   localparam logic [1:0] ST_STABLE_HI = 2'd2;
   localparam logic [1:0] ST_WAIT_LO   = 2'd3;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;
   logic [1:0]             r_state, w_state_nxt;
   logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
   logic                   r_level, w_level_nxt;
   logic                   r_busy, w_busy_nxt;

   // Flops preload the idle pad value so leaving reset never looks like a press.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= {SYNC_STAGES{IDLE_RAW}};
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1] ^ INVERT;

   always_comb begin
      // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
      w_state_nxt = r_state;
      w_cnt_nxt   = CNT_ZERO;
      w_level_nxt = r_level;
      case (r_state)
         ST_STABLE_LO: begin
            if (w_s) begin
               w_state_nxt = ST_WAIT_HI;
               w_cnt_nxt   = CNT_ONE;
            end
         end
         ST_WAIT_HI: begin
            if (!w_s) begin
               w_state_nxt = ST_STABLE_LO;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = ST_STABLE_HI;
               w_level_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         ST_STABLE_HI: begin
            if (!w_s) begin
               w_state_nxt = ST_WAIT_LO;
               w_cnt_nxt   = CNT_ONE;
            end
         end
         ST_WAIT_LO: begin
            if (w_s) begin
               w_state_nxt = ST_STABLE_HI;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = ST_STABLE_LO;
               w_level_nxt = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = ST_STABLE_LO;
            w_level_nxt = 1'b0;
         end
      endcase
      w_busy_nxt = (w_state_nxt == ST_WAIT_HI) || (w_state_nxt == ST_WAIT_LO);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_STABLE_LO;
         r_cnt   <= CNT_ZERO;
         r_level <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign level = r_level;
   assign busy  = r_busy;

`ifdef BUTTON_DEBOUNCE_GLITCH_COUNT_EN
   logic       w_glitch;
   logic [7:0] r_glitch_count;

   // A glitch is a bounce back to the current level while qualifying.
   assign w_glitch = ((r_state == ST_WAIT_HI) && !w_s) || ((r_state == ST_WAIT_LO) && w_s);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_glitch_count <= 8'd0;
      end else if (w_glitch && (r_glitch_count != 8'hFF)) begin
         r_glitch_count <= r_glitch_count + 8'd1;
      end
   end

   assign glitch_count = r_glitch_count;
`else
   assign glitch_count = 8'd0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed table, hand sequences and random bounce vs a run-length model.
module tb_button_debounce;
   localparam int SYNC = 2;
   localparam int STAB = 8;
`ifdef BUTTON_DEBOUNCE_GLITCH_COUNT_EN
   localparam bit GC_EN = 1'b1;
`else
   localparam bit GC_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       raw_a = 1'b0;
   logic       raw_b = 1'b1;
   logic       level_a, busy_a, level_b, busy_b;
   logic [7:0] gc_a, gc_b;

   always #5 clk = ~clk;

   button_debounce #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .INVERT(1'b0)) dut_a (
      .clk(clk), .reset_n(reset_n), .raw_in(raw_a),
      .level(level_a), .busy(busy_a), .glitch_count(gc_a)
   );

   button_debounce #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .INVERT(1'b1)) dut_b (
      .clk(clk), .reset_n(reset_n), .raw_in(raw_b),
      .level(level_b), .busy(busy_b), .glitch_count(gc_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: level flips once the synchronized input has disagreed with it for
   // STAB consecutive edges; any agreement before then is a glitch and restarts the run.
   logic m_pipe[2][SYNC];
   logic m_level[2];
   int   m_run[2];
   int   m_glitch[2];

   task automatic model_reset(input int k);
      for (int i = 0; i < SYNC; i++) m_pipe[k][i] = (k == 1);
      m_level[k]  = 1'b0;
      m_run[k]    = 0;
      m_glitch[k] = 0;
   endtask

   task automatic model_edge(input int k, input logic raw);
      logic s;
      s = m_pipe[k][SYNC-1] ^ (k == 1);
      for (int i = SYNC - 1; i > 0; i--) m_pipe[k][i] = m_pipe[k][i-1];
      m_pipe[k][0] = raw;
      if (s != m_level[k]) begin
         m_run[k]++;
         if (m_run[k] == STAB) begin
            m_level[k] = s;
            m_run[k]   = 0;
         end
      end else if (m_run[k] > 0) begin
         m_run[k] = 0;
         if (m_glitch[k] < 255) m_glitch[k]++;
      end
   endtask

   function automatic int model_word(input int k);
      return int'(m_level[k]) * 512 + int'(m_run[k] > 0) * 256 + (GC_EN ? m_glitch[k] : 0);
   endfunction

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic cycle();
      @(posedge clk);
      if (!reset_n) begin
         model_reset(0);
         model_reset(1);
      end else begin
         model_edge(0, raw_a);
         model_edge(1, raw_b);
      end
      @(negedge clk);
      check("model_a", int'(level_a) * 512 + int'(busy_a) * 256 + int'(gc_a), model_word(0));
      check("model_b", int'(level_b) * 512 + int'(busy_b) * 256 + int'(gc_b), model_word(1));
   endtask

   typedef struct {
      logic raw;
      int   cycles;
      logic level;
      logic busy;
      int   glitch;
   } vec_t;

   vec_t tbl[15];

   initial begin
      // Clean rise, hold, bounce while high, clean fall, bounce while low.
      tbl[0]  = '{1'b0, 3, 1'b0, 1'b0, 0};
      tbl[1]  = '{1'b1, 2, 1'b0, 1'b0, 0};
      tbl[2]  = '{1'b1, 1, 1'b0, 1'b1, 0};
      tbl[3]  = '{1'b1, 6, 1'b0, 1'b1, 0};
      tbl[4]  = '{1'b1, 1, 1'b1, 1'b0, 0};
      tbl[5]  = '{1'b1, 5, 1'b1, 1'b0, 0};
      tbl[6]  = '{1'b0, 4, 1'b1, 1'b1, 0};
      tbl[7]  = '{1'b1, 2, 1'b1, 1'b1, 0};
      tbl[8]  = '{1'b1, 1, 1'b1, 1'b0, 1};
      tbl[9]  = '{1'b1, 3, 1'b1, 1'b0, 1};
      tbl[10] = '{1'b0, 9, 1'b1, 1'b1, 1};
      tbl[11] = '{1'b0, 1, 1'b0, 1'b0, 1};
      tbl[12] = '{1'b0, 3, 1'b0, 1'b0, 1};
      tbl[13] = '{1'b1, 4, 1'b0, 1'b1, 1};
      tbl[14] = '{1'b0, 3, 1'b0, 1'b0, 2};

      model_reset(0);
      model_reset(1);
      #1;
      check("reset_level_a", int'(level_a), 0);
      check("reset_busy_a", int'(busy_a), 0);
      check("reset_gc_a", int'(gc_a), 0);
      check("reset_level_b", int'(level_b), 0);
      repeat (2) cycle();
      reset_n = 1'b1;
      repeat (4) cycle();
      check("inv_idle_level_b", int'(level_b), 0);

      foreach (tbl[i]) begin
         raw_a = tbl[i].raw;
         repeat (tbl[i].cycles) cycle();
         check($sformatf("tbl%0d_level", i), int'(level_a), int'(tbl[i].level));
         check($sformatf("tbl%0d_busy", i), int'(busy_a), int'(tbl[i].busy));
         check($sformatf("tbl%0d_gc", i), int'(gc_a), GC_EN ? tbl[i].glitch : 0);
      end

      // Reset in the middle of a rising qualification.
      raw_a = 1'b1;
      repeat (5) cycle();
      check("midq_busy_before", int'(busy_a), 1);
      reset_n = 1'b0;
      model_reset(0);
      model_reset(1);
      #1;
      check("midq_level", int'(level_a), 0);
      check("midq_busy", int'(busy_a), 0);
      check("midq_gc", int'(gc_a), 0);
      @(negedge clk);
      cycle();
      reset_n = 1'b1;
      repeat (9) cycle();
      check("post_rst_level_e9", int'(level_a), 0);
      cycle();
      check("post_rst_level_e10", int'(level_a), 1);

      // Saturation: 300 low-going bounces while level is high.
      for (int n = 0; n < 300; n++) begin
         raw_a = 1'b0;
         repeat (3) cycle();
         raw_a = 1'b1;
         repeat (3) cycle();
      end
      check("sat_gc", int'(gc_a), GC_EN ? 255 : 0);
      check("sat_level", int'(level_a), 1);

      // Active-low instance: pad driven low means pressed.
      raw_b = 1'b0;
      repeat (9) cycle();
      check("inv_level_e9", int'(level_b), 0);
      check("inv_busy_e9", int'(busy_b), 1);
      cycle();
      check("inv_level_e10", int'(level_b), 1);
      check("inv_busy_e10", int'(busy_b), 0);

      // Random bounce bursts of varying run lengths on both pads.
      for (int n = 0; n < 300; n++) begin
         raw_a = 1'($urandom_range(0, 1));
         raw_b = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 12)) cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/button_debounce.md
# button_debounce

Synchronizes and debounces one asynchronous mechanical input (button or switch) into a clean, single-clock-domain level. It sits directly upstream of the edge detector: its `level` output drives the edge detector's `signal` input, which then produces the one-cycle press/release pulse. Bounce shorter than the programmed stable window never reaches `level`.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops on `raw_in`; legal range 2..4.
- `STABLE_CYCLES`, 650000: consecutive cycles the synchronized input must differ from `level` before `level` changes (≈10 ms at 65 MHz); minimum 2.
- `INVERT`, 0: 1 = active-low input. `raw_in` is inverted after synchronization, so `level` is always active-high.

- `clk`  in  1  single clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `raw_in`  in  1  asynchronous pad input; may bounce.
- `level`  out  1  debounced, active-high, registered level.
- `busy`  out  1  registered; high while a candidate transition is being qualified.
- `glitch_count`  out  8  saturating count of rejected transitions (see Configuration).

## Operation
- Synchronizer: `SYNC_STAGES`-deep flop chain on `raw_in`. On reset every flop loads the idle value (`INVERT` ? 1 : 0), so no spurious transition occurs after reset. Call the polarity-corrected chain output `s`.
- Counter: `cnt` is $clog2(STABLE_CYCLES+1) bits wide, unsigned. It never wraps.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. Reset state is STABLE_LO.
  - STABLE_LO: if `s`=1, go to WAIT_HI with `cnt`←1. Otherwise hold with `cnt`=0.
  - WAIT_HI:
    - If `s`=0, go to STABLE_LO with `cnt`←0 and record a glitch.
    - Else if `cnt`=STABLE_CYCLES-1, go to STABLE_HI with `level`←1 and `cnt`←0.
    - Else `cnt`←`cnt`+1.
  - STABLE_HI and WAIT_LO: mirror images of the above with polarity swapped; the qualified exit sets `level`←0.
- `busy` = 1 exactly while in WAIT_HI or WAIT_LO.
- A bounce back to the current `level` value inside a WAIT state fully restarts qualification. Counts never accumulate across glitches.
- Reset values: `level`=0, `busy`=0, `glitch_count`=0, state STABLE_LO, `cnt`=0.
- Reset asserted mid-WAIT: the block returns to reset values immediately. The pending transition is discarded and `level` does not change.

## Timing
- Edge 1 is the first rising edge that samples a new `raw_in` value.
- `s` reflects the new value after edge SYNC_STAGES.
- `busy` rises on edge SYNC_STAGES+1.
- If `raw_in` is held, `level` and `busy` both update on edge SYNC_STAGES+STABLE_CYCLES. `busy` falls on the same edge that `level` changes.
- Latency is identical for rising and falling transitions.
- `level` is glitch-free (driven directly from a flop) and safe to feed the edge detector with no further synchronization.
- A `raw_in` pulse shorter than one clock may be missed entirely. This is by design.

## Configuration
- `BUTTON_DEBOUNCE_GLITCH_COUNT_EN` defined:
  - An 8-bit saturating counter increments on every WAIT→STABLE exit caused by bounce-back (glitch).
  - The counter holds at 255.
  - It resets to 0 only via `reset_n`.
- Not defined: `glitch_count` is tied to 8'd0 and no counter logic is synthesized. All other behaviour is unchanged.

## Test plan
All scenarios use SYNC_STAGES=2, STABLE_CYCLES=8, INVERT=0, macro defined, unless noted.
- Clean rise: after reset, drive `raw_in` 0→1 and hold → `busy` high on edges 3–9, `level` 0→1 on edge 10, `busy` low on edge 10, `glitch_count`=0.
- Bounce: `raw_in`=1 for 4 cycles, then 0 → `level` stays 0, `busy` high for 4 cycles then low, `glitch_count`=1. Then hold 1 for 20 cycles → `level`=1 on edge 10 after the final rise.
- Clean fall from `level`=1: `raw_in` 1→0 held → `level` 1→0 on edge 10; repeating the bounce pattern while high → `level` stays 1, `glitch_count` increments.
- INVERT=1: reset with `raw_in`=1 → `level`=0 with no transient. Drive `raw_in`=0 held → `level`=1 on edge 10.
- Reset mid-qualification: assert `reset_n`=0 at edge 6 of a rise → `level`=0, `busy`=0, `glitch_count`=0 immediately. After release with `raw_in` still 1 → `level`=1 exactly 10 edges after release.
- Saturation: 300 glitches → `glitch_count`=255. Rebuild without the macro → `glitch_count`=0 throughout, and `level`/`busy` traces identical to the macro-defined build.
